// File: rtl/sar_compare_search_pkg.sv
// Shared types and constants for the successive-approximation compare search.
// Holds the controller state encoding, the one-hot comparator codes and the
// step-counter width helper used to size the steps output.
package sar_compare_search_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Legal comparator responses, packed as {eq, gt, lt}
    localparam logic [2:0] CMP_EQ = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    // Bits needed to count 0..width compare cycles
    function automatic int step_w(input int width);
        return $clog2(width + 1);
    endfunction

    // True when exactly one of eq/gt/lt is asserted
    function automatic logic cmp_onehot(input logic [2:0] cmp);
        return (cmp == CMP_EQ) || (cmp == CMP_GT) || (cmp == CMP_LT);
    endfunction

endpackage

// File: rtl/sar_compare_search.sv
// Successive-approximation controller: drives trial to an external comparator, MSB first.
// Latency: first trial 1 cycle after start; done at most WIDTH+1 cycles after start.
// Backpressure: none; start is only sampled in IDLE, and is dropped while busy or in DONE.
module sar_compare_search
    import sar_compare_search_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [WIDTH-1:0]          trial,
    input  logic                      cmp_eq,
    input  logic                      cmp_gt,
    input  logic                      cmp_lt,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          result,
    output logic                      found,
    output logic                      err,
    output logic [step_w(WIDTH)-1:0]  steps
);

    localparam int STEP_W = step_w(WIDTH);
    localparam int BIT_W  = $clog2(WIDTH);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                found_q, found_d;
    logic                err_q, err_d;
    logic                eq_seen_q, eq_seen_d;

    // Per-step decision terms, all derived from current registers and the comparator
    logic [WIDTH-1:0]    trial_cur;
    logic [WIDTH-1:0]    acc_upd;
    logic                cmp_bad;
    logic                cmp_hit;
    logic                last_bit;
    logic                term;

    // Candidate operand and the outcome of sampling the comparator against it
    always_comb begin
        trial_cur = acc_q | (WIDTH'(1) << bit_q);
        acc_upd   = (cmp_eq || cmp_gt) ? trial_cur : acc_q;
        cmp_bad   = !cmp_onehot({cmp_eq, cmp_gt, cmp_lt});
        cmp_hit   = cmp_eq && EARLY_EXIT;
        last_bit  = (bit_q == '0);
        term      = cmp_bad || cmp_hit || last_bit;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DONE always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_SEARCH;
            ST_SEARCH: if (term)  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: accumulator, bit pointer and the held result set
    always_comb begin
        acc_d     = acc_q;
        bit_d     = bit_q;
        steps_d   = steps_q;
        result_d  = result_q;
        found_d   = found_q;
        err_d     = err_q;
        eq_seen_d = eq_seen_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    bit_d     = BIT_W'(WIDTH - 1);
                    steps_d   = '0;
                    result_d  = '0;
                    found_d   = 1'b0;
                    err_d     = 1'b0;
                    eq_seen_d = 1'b0;
                end
            end
            ST_SEARCH: begin
                steps_d = steps_q + STEP_W'(1);
                if (cmp_bad) begin
                    // Malformed comparator answer: report what was settled so far
                    err_d    = 1'b1;
                    result_d = acc_q;
                end else if (cmp_hit) begin
                    result_d = trial_cur;
                    found_d  = 1'b1;
                end else begin
                    acc_d     = acc_upd;
                    eq_seen_d = eq_seen_q || cmp_eq;
                    if (last_bit) begin
                        result_d = acc_upd;
                        found_d  = eq_seen_q || cmp_eq;
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            bit_q     <= '0;
            steps_q   <= '0;
            result_q  <= '0;
            found_q   <= 1'b0;
            err_q     <= 1'b0;
            eq_seen_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            bit_q     <= bit_d;
            steps_q   <= steps_d;
            result_q  <= result_d;
            found_q   <= found_d;
            err_q     <= err_d;
            eq_seen_q <= eq_seen_d;
        end
    end

    // Outputs: trial is only presented to the comparator while searching
    always_comb begin
        busy   = (state_q == ST_SEARCH);
        done   = (state_q == ST_DONE);
        trial  = (state_q == ST_SEARCH) ? trial_cur : '0;
        result = result_q;
        found  = found_q;
        err    = err_q;
        steps  = steps_q;
    end

endmodule

// File: tb/tb_sar_compare_search.sv
// Bench for sar_compare_search: two instances (early exit on / off) closed through comparator models.
// Expected trials, result, found and steps come from binary-search arithmetic on the target.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sar_compare_search;

    localparam int W  = 4;
    localparam int SW = 3;

    logic            clk;
    logic            rst_n;
    logic [1:0]      start_v;
    logic [W-1:0]    tgt [2];
    logic            force_bad;

    wire  [W-1:0]    trial_w  [2];
    wire  [W-1:0]    result_w [2];
    wire  [SW-1:0]   steps_w  [2];
    wire             busy_w   [2];
    wire             done_w   [2];
    wire             found_w  [2];
    wire             err_w    [2];
    wire             eq_w     [2];
    wire             gt_w     [2];
    wire             lt_w     [2];

    int n_checks;
    int n_errs;

    // Comparator models: a = target, b = trial; instance 0 can be forced to answer gt and lt together
    assign eq_w[0] = (tgt[0] == trial_w[0]);
    assign gt_w[0] = (tgt[0] >  trial_w[0]) || force_bad;
    assign lt_w[0] = (tgt[0] <  trial_w[0]) || force_bad;
    assign eq_w[1] = (tgt[1] == trial_w[1]);
    assign gt_w[1] = (tgt[1] >  trial_w[1]);
    assign lt_w[1] = (tgt[1] <  trial_w[1]);

    sar_compare_search #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .trial(trial_w[0]),
        .cmp_eq(eq_w[0]), .cmp_gt(gt_w[0]), .cmp_lt(lt_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]),
        .found(found_w[0]), .err(err_w[0]), .steps(steps_w[0])
    );

    sar_compare_search #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .trial(trial_w[1]),
        .cmp_eq(eq_w[1]), .cmp_gt(gt_w[1]), .cmp_lt(lt_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]),
        .found(found_w[1]), .err(err_w[1]), .steps(steps_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Trial probed when deciding bit b: target bits above b, plus bit b set
    function automatic int exp_trial(input int t, input int b);
        return ((t >> (b + 1)) << (b + 1)) | (1 << b);
    endfunction

    // Index of the lowest set bit (t must be nonzero)
    function automatic int low_bit(input int t);
        for (int i = 0; i < W; i++) begin
            if (t[i]) return i;
        end
        return 0;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One complete search on instance idx; bad2 corrupts the comparator on step 2 (instance 0 only)
    task automatic run_search(input int idx, input int t, input bit bad2);
        int  n;
        bit  saw_done;
        int  e_res, e_steps, e_found, e_err;
        if (bad2) begin
            e_res = t & (1 << (W - 1)); e_steps = 2; e_found = 0; e_err = 1;
        end else if (t == 0) begin
            e_res = 0; e_steps = W; e_found = 0; e_err = 0;
        end else begin
            e_res = t; e_found = 1; e_err = 0;
            e_steps = (idx == 0) ? (W - low_bit(t)) : W;
        end
        tgt[idx] = t[W-1:0];
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        n = 0;
        saw_done = 0;
        for (int c = 0; c < 3 * W && !saw_done; c++) begin
            if (done_w[idx]) begin
                saw_done = 1;
            end else begin
                if (!busy_w[idx]) check("busy_in_search", 0, 1);
                if (n < W) check($sformatf("trial_i%0d_t%0d_s%0d", idx, t, n), int'(trial_w[idx]), exp_trial(t, W - 1 - n));
                if (bad2 && n == 1) force_bad = 1'b1;
                n++;
                @(negedge clk);
            end
        end
        force_bad = 1'b0;
        if (!saw_done) begin
            check($sformatf("timeout_i%0d_t%0d", idx, t), 0, 1);
        end else begin
            check($sformatf("cycles_i%0d_t%0d", idx, t), n, e_steps);
            check($sformatf("result_i%0d_t%0d", idx, t), int'(result_w[idx]), e_res);
            check($sformatf("found_i%0d_t%0d", idx, t), int'(found_w[idx]), e_found);
            check($sformatf("err_i%0d_t%0d", idx, t), int'(err_w[idx]), e_err);
            check($sformatf("steps_i%0d_t%0d", idx, t), int'(steps_w[idx]), e_steps);
            check("done_trial_zero", int'(trial_w[idx]), 0);
            check("done_not_busy", int'(busy_w[idx]), 0);
            @(negedge clk);
            check("done_one_cycle", int'(done_w[idx]), 0);
            check("held_result", int'(result_w[idx]), e_res);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errs    = 0;
        rst_n     = 1'b0;
        start_v   = 2'b00;
        force_bad = 1'b0;
        tgt[0]    = '0;
        tgt[1]    = '0;
        idle_cycles(2);
        for (int i = 0; i < 2; i++) begin
            check("rst_busy",   int'(busy_w[i]),   0);
            check("rst_done",   int'(done_w[i]),   0);
            check("rst_trial",  int'(trial_w[i]),  0);
            check("rst_result", int'(result_w[i]), 0);
            check("rst_found",  int'(found_w[i]),  0);
            check("rst_err",    int'(err_w[i]),    0);
            check("rst_steps",  int'(steps_w[i]),  0);
        end
        rst_n = 1'b1;
        idle_cycles(1);

        // Directed cases
        run_search(0, 5, 0);
        run_search(0, 8, 0);
        run_search(0, 0, 0);
        run_search(0, 15, 0);
        run_search(1, 8, 0);
        run_search(1, 0, 0);
        run_search(0, 5, 1);

        // Start held through the whole search and DONE must not relaunch
        tgt[0] = 4'd8;
        start_v[0] = 1'b1;
        begin
            bit got_done;
            got_done = 0;
            for (int c = 0; c < 3 * W && !got_done; c++) begin
                @(negedge clk);
                got_done = done_w[0];
            end
            check("held_start_done", int'(got_done), 1);
        end
        @(negedge clk);
        check("held_start_ignored", int'(busy_w[0]), 0);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("held_start_idle", int'(busy_w[0]), 0);

        // Reset asserted while deciding the third bit
        tgt[0] = 4'd5;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_trial", int'(trial_w[0]), 6);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   int'(busy_w[0]),   0);
        check("midrst_trial",  int'(trial_w[0]),  0);
        check("midrst_result", int'(result_w[0]), 0);
        check("midrst_steps",  int'(steps_w[0]),  0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_no_done", int'(done_w[0]), 0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("postrst_idle", int'(busy_w[0]) + int'(done_w[0]), 0);
        end

        // Exhaustive targets on both variants with random spacing
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < (1 << W); t++) begin
                idle_cycles($urandom_range(3, 0));
                run_search(i, t, 0);
            end
        end

        // Random mix
        for (int k = 0; k < 24; k++) begin
            idle_cycles($urandom_range(2, 0));
            run_search(int'($urandom_range(1, 0)), int'($urandom_range((1 << W) - 1, 0)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
